// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexes one combinational LIF neuron datapath across NEURONS virtual neurons.
// Define NSCHED_SPIKE_COUNT_EN to add per-neuron saturating spike counters (cnt_sel/cnt_out).
module neuron_tdm_scheduler #(
    parameter int N_STAGES = 5,
    parameter int NEURONS  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    input  logic [7:0]               cfg_data,
    output logic                     cfg_ready,
    input  logic [2**N_STAGES-1:0]   x_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [NEURONS-1:0]       spikes_out,
`ifdef NSCHED_SPIKE_COUNT_EN
    input  logic [$clog2(NEURONS)-1:0] cnt_sel,
    output logic [7:0]               cnt_out,
`endif
    output logic [2**N_STAGES-1:0]   nrn_w,
    output logic [2**N_STAGES-1:0]   nrn_x,
    output logic [N_STAGES+1:0]      nrn_previus_u,
    output logic                     nrn_was_spike,
    output logic [2:0]               nrn_shift,
    output logic [N_STAGES+1:0]      nrn_minus_teta,
    input  logic [N_STAGES+1:0]      nrn_u_out,
    input  logic                     nrn_is_spike
);

    localparam int INPUTS           = 2**N_STAGES;
    localparam int OUTPUT_PRECISION = N_STAGES + 2;
    localparam int BPN              = INPUTS / 8;
    localparam int NB               = NEURONS * BPN + 2;
    localparam int IDX_W            = $clog2(NEURONS);
    localparam int BC_W             = $clog2(NB);
    localparam logic [OUTPUT_PRECISION-1:0] MINUS_TETA_RST = OUTPUT_PRECISION'(-5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LATCH,
        S_EVAL,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [INPUTS-1:0]           w_mem [NEURONS];
    logic [OUTPUT_PRECISION-1:0] u_mem [NEURONS];
    logic [NEURONS-1:0]          was_spike;
    logic [NEURONS-1:0]          spike_shadow;
    logic [INPUTS-1:0]           x_lat;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            rd_idx;
    logic [BC_W-1:0]             byte_cnt;
    logic [IDX_W-1:0]            byte_nrn;
    logic [BC_W-1:0]             byte_lane;
    logic [2:0]                  shift;
    logic [OUTPUT_PRECISION-1:0] minus_teta;
    logic [OUTPUT_PRECISION-1:0] teta_ext;
    logic                        cfg_accept;
    logic                        last_byte;
    logic                        shift_byte;
    logic                        idx_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start wins over cfg_valid in IDLE; the byte offered alongside it is left unconsumed
    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = !start;
                if (start) begin
                    next_state = S_LATCH;
                end else if (cfg_valid) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && last_byte) begin
                    next_state = S_IDLE;
                end
            end
            S_LATCH: begin
                busy       = 1'b1;
                next_state = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                if (idx_last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign cfg_accept = cfg_valid && cfg_ready;
    assign last_byte  = (byte_cnt == BC_W'(NB - 1));
    assign shift_byte = (byte_cnt == BC_W'(NB - 2));
    assign idx_last   = (idx == IDX_W'(NEURONS - 1));

    always_comb begin
        byte_nrn  = IDX_W'(32'(byte_cnt) / BPN);
        byte_lane = BC_W'(32'(byte_cnt) % BPN);
    end

    // threshold byte is sign-extended when the datapath is wider than a byte
    always_comb begin
        teta_ext = '0;
        for (int i = 0; i < OUTPUT_PRECISION; i++) begin
            teta_ext[i] = (i < 8) ? cfg_data[i[2:0]] : cfg_data[7];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NEURONS; n++) begin
                w_mem[n] <= '0;
                u_mem[n] <= '0;
            end
            was_spike    <= '0;
            spike_shadow <= '0;
            spikes_out   <= '0;
            x_lat        <= '0;
            idx          <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            minus_teta   <= MINUS_TETA_RST;
        end else begin
            if (cfg_accept) begin
                if (last_byte) begin
                    minus_teta <= teta_ext;
                    byte_cnt   <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (shift_byte) begin
                        shift <= cfg_data[2:0];
                    end else begin
                        for (int l = 0; l < BPN; l++) begin
                            if (byte_lane == BC_W'(l)) begin
                                w_mem[byte_nrn][l*8 +: 8] <= cfg_data;
                            end
                        end
                    end
                end
            end

            case (state)
                S_LATCH: begin
                    x_lat <= x_in;
                    idx   <= '0;
                end
                S_EVAL: begin
                    u_mem[idx]        <= nrn_u_out;
                    was_spike[idx]    <= nrn_is_spike;
                    spike_shadow[idx] <= nrn_is_spike;
                    idx               <= idx_last ? '0 : idx + 1'b1;
                end
                S_DONE: begin
                    spikes_out <= spike_shadow;
                end
                default: ;
            endcase
        end
    end

    assign rd_idx         = (state == S_EVAL) ? idx : '0;
    assign nrn_w          = w_mem[rd_idx];
    assign nrn_previus_u  = u_mem[rd_idx];
    assign nrn_was_spike  = was_spike[rd_idx];
    assign nrn_x          = x_lat;
    assign nrn_shift      = shift;
    assign nrn_minus_teta = minus_teta;

`ifdef NSCHED_SPIKE_COUNT_EN
    logic [7:0] spk_cnt [NEURONS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NEURONS; n++) begin
                spk_cnt[n] <= '0;
            end
        end else if (state == S_EVAL && nrn_is_spike && spk_cnt[idx] != 8'hFF) begin
            spk_cnt[idx] <= spk_cnt[idx] + 8'd1;
        end
    end

    assign cnt_out = spk_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_neuron_tdm_scheduler.sv
// Directed bench for neuron_tdm_scheduler with a u+1 datapath stub.
// Counter checks are compiled in when NSCHED_SPIKE_COUNT_EN is defined.
module tb_neuron_tdm_scheduler;

    localparam int N_STAGES = 5;
    localparam int NEURONS  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_ready;
    logic [31:0] x_in = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  spikes_out;
    logic [31:0] nrn_w;
    logic [31:0] nrn_x;
    logic [6:0]  nrn_previus_u;
    logic        nrn_was_spike;
    logic [2:0]  nrn_shift;
    logic [6:0]  nrn_minus_teta;
    logic [6:0]  nrn_u_out;
    logic        nrn_is_spike;
    logic        force_spike = 1'b0;
`ifdef NSCHED_SPIKE_COUNT_EN
    logic [2:0]  cnt_sel = '0;
    logic [7:0]  cnt_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_w [8];
    logic [6:0]  exp_u [8];
    logic [7:0]  exp_ws;
    logic [7:0]  exp_shadow;
    logic [7:0]  exp_spk;
    int          exp_cnt [8];

    neuron_tdm_scheduler #(.N_STAGES(N_STAGES), .NEURONS(NEURONS)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .cfg_ready      (cfg_ready),
        .x_in           (x_in),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .spikes_out     (spikes_out),
`ifdef NSCHED_SPIKE_COUNT_EN
        .cnt_sel        (cnt_sel),
        .cnt_out        (cnt_out),
`endif
        .nrn_w          (nrn_w),
        .nrn_x          (nrn_x),
        .nrn_previus_u  (nrn_previus_u),
        .nrn_was_spike  (nrn_was_spike),
        .nrn_shift      (nrn_shift),
        .nrn_minus_teta (nrn_minus_teta),
        .nrn_u_out      (nrn_u_out),
        .nrn_is_spike   (nrn_is_spike)
    );

    always #5 clk = ~clk;

    assign nrn_u_out    = nrn_previus_u + 7'd1;
    assign nrn_is_spike = force_spike | (nrn_u_out == 7'd3);

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int n = 0; n < 8; n++) begin
            exp_w[n]   = '0;
            exp_u[n]   = '0;
            exp_cnt[n] = 0;
        end
        exp_ws     = '0;
        exp_shadow = '0;
        exp_spk    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reset_model();
    endtask

    task automatic send_cfg(input int gap, input logic [7:0] base, input logic [7:0] sh, input logic [7:0] te);
        logic [7:0] b;
        for (int j = 0; j < 34; j++) begin
            if (j < 32) b = base + 8'(j);
            else if (j == 32) b = sh;
            else b = te;
            @(negedge clk);
            cfg_valid = 1'b1;
            cfg_data  = b;
            #1;
            check("cfg_ready", cfg_ready, 1);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                cfg_valid = 1'b0;
            end
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("nrn_shift", nrn_shift, sh[2:0]);
        check("nrn_minus_teta", nrn_minus_teta, te[6:0]);
        for (int n = 0; n < 8; n++)
            for (int l = 0; l < 4; l++)
                exp_w[n][8*l +: 8] = base + 8'(n*4 + l);
    endtask

    task automatic run_ts(input logic [31:0] x, input bit mid_start, input bit collide);
        int dones;
        int i;
        logic [6:0] nu;
        dones = 0;
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        if (collide) begin
            cfg_valid = 1'b1;
            cfg_data  = 8'hAA;
            #1;
            check("cfg_ready_collide", cfg_ready, 0);
        end
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start     = mid_start && (k == 4);
            cfg_valid = 1'b0;
            if (k == 2) x_in = ~x;
            #1;
            if (done) dones++;
            if (k <= 9) check("busy", busy, 1);
            if (k >= 2 && k <= 9) begin
                i = k - 2;
                check("nrn_x", nrn_x, x);
                check("nrn_w", nrn_w, exp_w[i]);
                check("nrn_previus_u", nrn_previus_u, exp_u[i]);
                check("nrn_was_spike", nrn_was_spike, exp_ws[i]);
                nu            = exp_u[i] + 7'd1;
                exp_u[i]      = nu;
                exp_shadow[i] = force_spike || (nu == 7'd3);
                exp_ws[i]     = exp_shadow[i];
                if (exp_shadow[i] && exp_cnt[i] < 255) exp_cnt[i]++;
            end
            if (k == 10) begin
                check("done_pulse", done, 1);
                check("busy_in_done", busy, 0);
                check("spikes_stable", spikes_out, exp_spk);
            end
            if (k == 11) begin
                exp_spk = exp_shadow;
                check("spikes_out", spikes_out, exp_spk);
                check("done_low", done, 0);
            end
        end
        check("done_count", dones, 1);
    endtask

    initial begin
        int dones;
        reset_model();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_spikes_out", spikes_out, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_minus_teta", nrn_minus_teta, 7'b1111011);
        check("rst_shift", nrn_shift, 0);
        check("rst_cfg_ready", cfg_ready, 1);

        send_cfg(0, 8'h01, 8'h03, 8'h7A);
        check("w1_spec", exp_w[1], 32'h08070605);
        run_ts(32'hDEADBEEF, 0, 0);
        check("spikes_ts1", spikes_out, 8'h00);
        run_ts(32'hDEADBEEF, 0, 0);
        check("spikes_ts2", spikes_out, 8'h00);
        run_ts(32'hDEADBEEF, 0, 0);
        check("spikes_ts3", spikes_out, 8'hFF);

        // reset while EVAL is at idx 4
        @(negedge clk);
        x_in  = 32'h12345678;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_spikes", spikes_out, 8'h00);
        check("mid_rst_teta", nrn_minus_teta, 7'h7B);
        check("mid_rst_shift", nrn_shift, 0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (done) dones++;
        end
        check("mid_rst_no_done", dones, 0);
        reset_model();
        run_ts(32'hA5A5A5A5, 0, 0);

        send_cfg(2, 8'h01, 8'h03, 8'h7A);
        run_ts(32'hCAFEF00D, 1, 0);
        run_ts(32'h0F0F0F0F, 0, 1);
        check("spikes_collide_ts", spikes_out, 8'hFF);
        send_cfg(0, 8'h40, 8'h05, 8'h11);
        run_ts(32'h00FF00FF, 0, 0);

`ifdef NSCHED_SPIKE_COUNT_EN
        do_reset();
        force_spike = 1'b1;
        for (int t = 0; t < 300; t++) run_ts(32'h1, 0, 0);
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            check("cnt_sat", cnt_out, 8'(exp_cnt[s]));
            check("cnt_sat_abs", cnt_out, 8'd255);
        end
        force_spike = 1'b0;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            check("cnt_rst", cnt_out, 8'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_tdm_scheduler.md
Name: neuron_tdm_scheduler

Overview:
Time-multiplexes one combinational LIF `neuron` datapath across NEURONS virtual neurons. Holds, per neuron:
- the weight vector
- membrane potential `u`
- the previous-spike bit

Streams configuration bytes in. On `start`, latches one input spike vector and evaluates every neuron once, one neuron per cycle, writing results back. This is one network timestep. It sits between the TT pin wrapper and a single `neuron #(.n_stage(N_STAGES))` instance.

Parameters:
- N_STAGES, 5, neuron adder-tree depth; INPUTS=2**N_STAGES, OUTPUT_PRECISION=N_STAGES+2 (localparams)
- NEURONS, 8, virtual neurons; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  config byte valid
- cfg_data  in  8  config byte
- cfg_ready  out  1  config byte accepted when cfg_valid&cfg_ready
- x_in  in  INPUTS  input spike vector
- start  in  1  request one timestep
- busy  out  1  high in LATCH/EVAL
- done  out  1  one-cycle pulse, timestep complete
- spikes_out  out  NEURONS  spike bits of last timestep, bit i = neuron i
- nrn_w  out  INPUTS  weights of current neuron
- nrn_x  out  INPUTS  latched inputs
- nrn_previus_u  out  OUTPUT_PRECISION  stored u of current neuron
- nrn_was_spike  out  1  stored spike bit of current neuron
- nrn_shift  out  3  leak shift (global)
- nrn_minus_teta  out  OUTPUT_PRECISION  negated threshold (global)
- nrn_u_out  in  OUTPUT_PRECISION  datapath result
- nrn_is_spike  in  1  datapath spike

Behaviour:
- Reset values:
  - state=IDLE; all weights=0, u=0, was_spike=0, spikes_out=0, x latch=0
  - shift=0, minus_teta=-5 (two's complement, all OUTPUT_PRECISION bits)
  - busy=0, done=0, cfg counters=0
- States:
  - IDLE: on start, go to LATCH. Start has priority over cfg_valid in the same cycle. Otherwise cfg_valid → LOAD, and that byte is consumed.
  - LOAD: cfg_ready=1. Total bytes B=NEURONS*INPUTS/8+2.
    - Weights: neuron 0 first, within a neuron the least-significant byte first.
    - Byte B-2: shift=data[2:0].
    - Byte B-1: minus_teta=data[OUTPUT_PRECISION-1:0], sign-extended if OUTPUT_PRECISION>8 (not the case at default).
    - After byte B-1 is accepted: return to IDLE, byte counter wraps to 0.
    - Gaps (cfg_valid=0) are allowed; counter holds. start is ignored in LOAD.
    - u and was_spike are not touched by configuration.
  - cfg_ready = (state==LOAD) | (state==IDLE & !start).
  - LATCH (1 cycle): x latch<=x_in; idx<=0.
  - EVAL (NEURONS cycles):
    - Drive nrn_* from entry idx.
    - At the clock edge: u[idx]<=nrn_u_out; was_spike[idx]<=nrn_is_spike; spike shadow[idx]<=nrn_is_spike.
    - idx increments; at idx==NEURONS-1 it wraps to 0 → DONE.
  - DONE (1 cycle): done=1, spikes_out<=spike shadow, → IDLE.
- Latency: start sampled in IDLE at cycle T → done high in cycle T+NEURONS+2. Back-to-back start is accepted in the cycle after done.
- Outside EVAL, nrn_w/nrn_previus_u/nrn_was_spike show entry 0. nrn_x always shows the latch.
- x_in changes after LATCH have no effect on the current timestep. start while busy is ignored.
- u is stored verbatim; the scheduler performs no arithmetic on it. Overflow and saturation belong to the datapath.
- spikes_out is stable between DONE pulses.
- Reset mid-LOAD or mid-EVAL: all state returns to reset values, partial config is discarded, no done pulse.

Optional Feature:
- NSCHED_SPIKE_COUNT_EN, when defined:
  - Adds input cnt_sel[$clog2(NEURONS)-1:0] and output cnt_out[7:0].
  - Adds one 8-bit spike counter per neuron. It increments in EVAL when nrn_is_spike=1, saturates at 255, and is cleared by reset only.
  - cnt_out = counter[cnt_sel], combinational.
- Undefined: no counters, no cnt_sel/cnt_out ports; behaviour is otherwise identical.

Test Plan:
- Reset → spikes_out=0, busy=0, done=0, nrn_minus_teta=7'b1111011, nrn_shift=0, cfg_ready=1.
- Stream B=34 bytes (0x01..0x20 for weights, then 0x03, 0x7A) → during EVAL at idx=1, nrn_w=32'h08070605; nrn_shift=3; nrn_minus_teta=7'h7A; back in IDLE after byte 34. Insert 2-cycle cfg_valid gaps → same result.
- Datapath stub u_out=previus_u+1, is_spike=(u_out==3) → x_in=32'hDEADBEEF, start at T:
  - busy high T+1..T+9, done only at T+10, nrn_x=32'hDEADBEEF.
  - Timesteps 1–2: spikes_out=0x00. Timestep 3: spikes_out=0xFF.
- Same stub, start and cfg_valid both high in IDLE → timestep runs, cfg_ready=0 that cycle, byte not consumed. start pulsed during EVAL → ignored, exactly one done.
- Reset asserted at EVAL idx=4 → next cycle IDLE, nrn_previus_u=0 for all entries on next run, weights=0, no done pulse.
- With NSCHED_SPIKE_COUNT_EN and stub is_spike=1 always: 300 timesteps → cnt_out=255 for every cnt_sel; reset → 0.
